// File: rtl/bus_buffer_fifo_if.sv
// Bus bundle for bus_buffer_fifo: write side, read handshake, output gate and status.
// The master side is the host/producer, the slave side is the buffer itself.
interface bus_buffer_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                   mode;
    logic [WIDTH-1:0]       A;
    logic                   wr_strobe;
    logic                   wr_ready;
    logic                   rd_ack;
    logic                   rd_valid;
    logic                   nOE;
    logic [WIDTH-1:0]       Y;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic                   underflow;
    logic                   clr_flags;

    modport master (
        output mode, A, wr_strobe, rd_ack, nOE, clr_flags,
        input  wr_ready, rd_valid, Y, count, overflow, underflow
    );

    modport slave (
        input  mode, A, wr_strobe, rd_ack, nOE, clr_flags,
        output wr_ready, rd_valid, Y, count, overflow, underflow
    );
endinterface

// File: rtl/bus_buffer_fifo.sv
// Parametrised bus buffer between host data latch and SCSI data register.
// Latch mode holds one word; FIFO mode is first-word-fall-through with sticky error flags.
module bus_buffer_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter bit INVERT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    bus_buffer_fifo_if.slave bus
);
    localparam int             PW   = $clog2(DEPTH);
    localparam int             CW   = PW + 1;
    localparam logic [CW-1:0]  FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_latch;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_modePrev;
    logic             r_overflow;
    logic             r_underflow;

    logic [WIDTH-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_modeChange;
    logic             w_fifoActive;
    logic             w_push;
    logic             w_pop;
    logic             w_ovfEvent;
    logic             w_unfEvent;

    // The registered mode selects the data source, so a pending mode change never glitches Y.
    assign w_head       = r_modePrev ? r_mem[r_rptr] : r_latch;
    assign w_full       = (r_count == FULL);
    assign w_empty      = (r_count == '0);
    assign w_modeChange = (bus.mode != r_modePrev);
    assign w_fifoActive = r_modePrev && !w_modeChange;
    assign w_push       = w_fifoActive && bus.wr_strobe && !w_full;
    assign w_pop        = w_fifoActive && bus.rd_ack && !w_empty;
    assign w_ovfEvent   = w_fifoActive && bus.wr_strobe && w_full;
    assign w_unfEvent   = w_fifoActive && bus.rd_ack && w_empty;

    assign bus.wr_ready  = !r_modePrev || !w_full;
    assign bus.rd_valid  = !w_empty;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

    // An empty buffer drives zero even with INVERT set, so cleared storage never shows as all-ones.
    assign bus.Y = (bus.nOE || w_empty) ? '0 : (INVERT ? ~w_head : w_head);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_latch     <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_modePrev  <= bus.mode;
        end else begin
            r_modePrev <= bus.mode;
            if (w_modeChange) begin
                r_latch <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else if (!r_modePrev) begin
                if (bus.wr_strobe) begin
                    r_latch <= bus.A;
                    r_count <= CW'(1);
                end
            end else begin
                if (w_push) begin
                    r_mem[r_wptr] <= bus.A;
                    r_wptr        <= r_wptr + PW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PW'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CW'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CW'(1);
                end
            end

            // A new error event outranks a clear arriving on the same edge.
            if (w_ovfEvent) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_flags) begin
                r_overflow <= 1'b0;
            end
            if (w_unfEvent) begin
                r_underflow <= 1'b1;
            end else if (bus.clr_flags) begin
                r_underflow <= 1'b0;
            end
        end
    end
endmodule

// File: doc/bus_buffer_fifo.md
# bus_buffer_fifo

Parametrised successor to the CPLD's octal inverting bus buffer. Sits on the buried data path between the host-bus data latch and the SCSI-side data register. Adds to the plain enable-gated buffer: configurable width, optional inversion, a latch mode, and a first-word-fall-through FIFO mode with a valid/ack handshake and sticky error flags. Outputs are never high-Z; disabled outputs drive zero, and bidirectional control stays at the top level.

## Interface
- WIDTH, 8, data width in bits (1..16).
- DEPTH, 4, FIFO depth in words; power of two, 2..16.
- INVERT, 1, 1: Y carries the bitwise complement of stored data; 0: Y carries true data.
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- mode  input  1  0 = latch mode, 1 = FIFO mode.
- A  input  WIDTH  write data.
- wr_strobe  input  1  write request; sampled on each clock edge.
- wr_ready  output  WIDTH-independent 1  write accepted this cycle if wr_strobe is high.
- rd_ack  input  1  consumer pop of the head word (FIFO mode only).
- rd_valid  output  1  Y holds a valid word.
- nOE  input  1  active-low output enable for Y. Combinational gate: Y = 0 when nOE is 1.
- Y  output  WIDTH  head/latched data, inverted per INVERT, gated by nOE.
- count  output  $clog2(DEPTH)+1  words held (FIFO) or 0/1 (latch).
- overflow  output  1  sticky flag: write attempted while full.
- underflow  output  1  sticky flag: rd_ack while empty.
- clr_flags  input  1  clears overflow and underflow on the next edge.

## Operation
- Reset values: count=0, rd_valid=0, wr_ready=1, overflow=0, underflow=0, storage cleared to 0, read and write pointers = 0. Y = 0 whatever the nOE level.
- Output path: Y = nOE ? 0 : (INVERT ? ~head : head). This is the only combinational path. head is registered storage.

Latch mode (mode=0):
- wr_ready is always 1.
- wr_strobe=1 captures A into the latch register. The next cycle, rd_valid=1 and count=1.
- rd_ack is ignored. It never sets underflow.
- The latch holds its value until the next strobe or until reset.

FIFO mode (mode=1):
- Push occurs when wr_strobe && wr_ready. A is written at wptr, wptr increments modulo DEPTH, and count increments.
- Pop occurs when rd_ack && rd_valid. rptr increments modulo DEPTH, and count decrements.
- Push and pop in the same cycle with 0<count<DEPTH: both happen and count is unchanged.
- wr_ready = (count != DEPTH). Writes are refused while full, even if a pop occurs in the same cycle.
- wr_strobe while full: the data is dropped, overflow is set, and state is otherwise unchanged.
- rd_ack while empty: no effect on the pointers, and underflow is set.
- rd_valid = (count != 0). Y shows the word at rptr (first-word fall-through).

Pointers and flags:
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. count is one bit wider so that "full" can be represented.
- Mode change: on the first edge where mode differs from its registered previous value, the FIFO is flushed. Pointers, count and rd_valid go to 0, and any strobe or ack in that cycle is ignored. The latch register is cleared as well. overflow and underflow are kept.
- If clr_flags and a new error event occur in the same cycle, the flag stays set (set wins).
- Reset mid-operation: all state returns to reset values on that edge, and any strobe or ack in that cycle is ignored.

## Timing
- Write to Y: a word pushed at edge N, into an empty FIFO or the latch, appears on Y and raises rd_valid after edge N (latency 1).
- Pop to next word: a pop at edge N presents the next word after edge N.
- count, wr_ready and the flags all update on the same edge as the event that causes them.
- nOE to Y: combinational, with no clock latency.
- Mode flush takes 1 cycle. The first accepted push in the new mode is on edge N+1 after the change is seen at edge N.

## Test plan
- Reset and gating:
  - Assert reset, then release it. Required: Y=0, count=0, rd_valid=0, wr_ready=1, flags=0.
  - With nOE=1 and a loaded latch, Y must be 0.
- Latch mode, WIDTH=8, INVERT=1:
  - Strobe A=8'h5A with nOE=0. Required next cycle: Y=8'hA5, rd_valid=1.
  - Pulse rd_ack. Required: Y stays 8'hA5 and underflow stays 0.
- FIFO fill and overflow, DEPTH=4:
  - Push 01,02,03,04. Required: count=4, wr_ready=0, Y=~01.
  - Push 05. Required: overflow=1, count=4.
  - Pop four times. Required: Y reads ~02, ~03, ~04 in turn, then rd_valid=0.
- Simultaneous push and pop:
  - With count=2, assert wr_strobe and rd_ack together for 6 cycles. Required: count stays 2, pointers wrap past DEPTH, and the data order is preserved.
- Underflow and flag clear:
  - rd_ack while empty. Required: underflow=1, count=0.
  - clr_flags together with a second empty rd_ack. Required: underflow stays 1.
  - clr_flags alone. Required: underflow=0.
- Mode flush and mid-operation reset:
  - With count=3 in FIFO mode, switch mode to 0. Required next cycle: count=0, rd_valid=0; overflow is retained.
  - Separately, reset with count=2 and wr_strobe high. Required: count=0 and the word is not stored.
